// File: rtl/mem_merge_if.sv
// Memory request bus: a valid/ready handshake carrying one read/write request.
// The request producer uses master/out, the consumer uses slave/in.
interface mem_intf #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 4,
  parameter int unsigned ID_WIDTH   = 4
);
  logic                  valid;
  logic                  ready;
  logic                  read_enable;
  logic [MASK_WIDTH-1:0] write_enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic [ID_WIDTH-1:0]   id;

  modport master (
    output valid, read_enable, write_enable, addr, data, id,
    input  ready
  );

  modport slave (
    input  valid, read_enable, write_enable, addr, data, id,
    output ready
  );

  // Names used by existing instantiations; same directions as master/slave.
  modport out (
    output valid, read_enable, write_enable, addr, data, id,
    input  ready
  );

  modport in (
    input  valid, read_enable, write_enable, addr, data, id,
    output ready
  );
endinterface

// File: rtl/mem_merge.sv
// mem_merge: arbitrates PORTS request streams onto one output through a
// 2-entry skid FIFO. The winning port index is prepended to the request id
// so responses can be routed back. Round-robin or fixed-priority arbitration.
module mem_merge #(
  parameter logic [63:0] CLOCK_INFO   = '0,  // clock descriptor, not used by the datapath
  parameter int unsigned ARB_MODE     = 0,   // 0: round robin, otherwise fixed priority
  parameter int unsigned PORTS        = 2,
  parameter int unsigned META_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MASK_WIDTH   = 4,
  parameter int unsigned PRE_ID_WIDTH = 4,
  parameter int unsigned OUT_ID_WIDTH = PRE_ID_WIDTH + ((PORTS > 1) ? $clog2(PORTS) : 0)
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_intf.in                   mem_in [PORTS],
  input  logic [META_WIDTH-1:0] mem_in_meta [PORTS],
  mem_intf.out                  mem_out,
  output logic [META_WIDTH-1:0] mem_out_meta
);

  localparam int unsigned SUB_ID_WIDTH = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef logic [SUB_ID_WIDTH-1:0] ptr_t;

  typedef struct packed {
    logic                    re;
    logic [MASK_WIDTH-1:0]   we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [OUT_ID_WIDTH-1:0] id;
    logic [META_WIDTH-1:0]   meta;
  } entry_t;

  // Elaboration-time width and range checks
  if (PORTS < 1 || PORTS > 16) begin : g_chk_ports
    $error("mem_merge: PORTS must be in 1..16");
  end
  if (PORTS > 1 && OUT_ID_WIDTH != PRE_ID_WIDTH + SUB_ID_WIDTH) begin : g_chk_id_multi
    $error("mem_merge: OUT_ID_WIDTH must equal PRE_ID_WIDTH + SUB_ID_WIDTH");
  end
  if (PORTS == 1 && OUT_ID_WIDTH != PRE_ID_WIDTH) begin : g_chk_id_single
    $error("mem_merge: OUT_ID_WIDTH must equal PRE_ID_WIDTH for a single port");
  end
  if ($bits(CLOCK_INFO) != 64) begin : g_chk_clock_info
    $error("mem_merge: unexpected clock descriptor width");
  end
  if ($bits(mem_out.addr) != ADDR_WIDTH || $bits(mem_out.data) != DATA_WIDTH ||
      $bits(mem_out.write_enable) != MASK_WIDTH || $bits(mem_out.id) != OUT_ID_WIDTH)
  begin : g_chk_out_widths
    $error("mem_merge: mem_out field widths do not match parameters");
  end

  logic             w_valid [PORTS];
  entry_t           w_req   [PORTS];
  logic [PORTS-1:0] w_grant;
  logic             w_any;
  ptr_t             w_sel;
  int unsigned      w_idx;
  logic             w_can_push;
  logic             w_push;
  logic             w_pop;
  entry_t           w_head;

  ptr_t             r_ptr;
  logic [1:0]       r_count;
  logic             r_wr;
  logic             r_rd;
  entry_t           r_mem [2];

  // Per-port unpacking, ready return and id tagging
  for (genvar g = 0; g < PORTS; g++) begin : g_port
    if ($bits(mem_in[g].addr) != ADDR_WIDTH || $bits(mem_in[g].data) != DATA_WIDTH ||
        $bits(mem_in[g].write_enable) != MASK_WIDTH || $bits(mem_in[g].id) != PRE_ID_WIDTH)
    begin : g_chk_in_widths
      $error("mem_merge: mem_in field widths do not match parameters");
    end

    assign w_valid[g]      = mem_in[g].valid;
    assign mem_in[g].ready = w_grant[g];

    if (PORTS > 1) begin : g_tag
      assign w_req[g] = {mem_in[g].read_enable, mem_in[g].write_enable, mem_in[g].addr,
                         mem_in[g].data, ptr_t'(g), mem_in[g].id, mem_in_meta[g]};
    end else begin : g_notag
      assign w_req[g] = {mem_in[g].read_enable, mem_in[g].write_enable, mem_in[g].addr,
                         mem_in[g].data, mem_in[g].id, mem_in_meta[g]};
    end
  end

  // Arbitration: pick one valid port, searching upward from the pointer (RR) or from 0 (fixed)
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = 0;
    if (ARB_MODE == 0) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        w_idx = 32'(r_ptr) + i;
        if (w_idx >= PORTS) w_idx = w_idx - PORTS;
        if (!w_any && w_valid[ptr_t'(w_idx)]) begin
          w_any = 1'b1;
          w_sel = ptr_t'(w_idx);
        end
      end
    end else begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (!w_any && w_valid[ptr_t'(i)]) begin
          w_any = 1'b1;
          w_sel = ptr_t'(i);
        end
      end
    end
  end

  // Grant gating: room in the FIFO (or a pop this cycle), forced off during reset
  // so ready drops asynchronously with rst.
  always_comb begin
    w_grant    = '0;
    w_can_push = !rst && ((r_count != 2'd2) || mem_out.ready);
    w_push     = w_any && w_can_push;
    w_pop      = (r_count != 2'd0) && mem_out.ready;
    if (w_push) w_grant[w_sel] = 1'b1;
  end

  // FIFO pointers, occupancy and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_ptr   <= '0;
    end else begin
      if (w_push) begin
        r_wr  <= ~r_wr;
        r_ptr <= (w_sel == ptr_t'(PORTS - 1)) ? '0 : w_sel + ptr_t'(1);
      end
      if (w_pop) r_rd <= ~r_rd;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload storage; when full with a pop, the tail slot is the head being freed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_req[w_sel];
  end

  assign w_head               = r_mem[r_rd];
  assign mem_out.valid        = (r_count != 2'd0);
  assign mem_out.read_enable  = w_head.re;
  assign mem_out.write_enable = w_head.we;
  assign mem_out.addr         = w_head.addr;
  assign mem_out.data         = w_head.data;
  assign mem_out.id           = w_head.id;
  assign mem_out_meta         = w_head.meta;

endmodule

// File: tb/tb_mem_merge.sv
// Bench for mem_merge: round-robin and fixed-priority 4-port instances share
// stimulus; a 1-port instance covers the untagged id path and a random soak.
module tb_mem_merge;
  localparam int unsigned NP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        in_valid [NP];
  logic        in_re    [NP];
  logic [1:0]  in_we    [NP];
  logic [15:0] in_addr  [NP];
  logic [15:0] in_data  [NP];
  logic [4:0]  in_id    [NP];
  logic [3:0]  in_meta  [NP];
  logic        out_ready;

  logic        p1_valid, p1_re;
  logic [1:0]  p1_we;
  logic [15:0] p1_addr, p1_data;
  logic [7:0]  p1_id;
  logic [3:0]  p1_meta [1];

  logic [3:0]  rr_meta_o, fx_meta_o, p1_meta_o;
  logic        rr_rdy [NP];
  logic        fx_rdy [NP];
  logic [3:0]  rr_gnt, fx_gnt;

  mem_intf #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MASK_WIDTH(2), .ID_WIDTH(5)) rr_in [NP] ();
  mem_intf #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MASK_WIDTH(2), .ID_WIDTH(5)) fx_in [NP] ();
  mem_intf #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MASK_WIDTH(2), .ID_WIDTH(7)) rr_out ();
  mem_intf #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MASK_WIDTH(2), .ID_WIDTH(7)) fx_out ();
  mem_intf #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MASK_WIDTH(2), .ID_WIDTH(8)) p1_in [1] ();
  mem_intf #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MASK_WIDTH(2), .ID_WIDTH(8)) p1_out ();

  for (genvar g = 0; g < NP; g++) begin : g_drv
    assign rr_in[g].valid        = in_valid[g];
    assign rr_in[g].read_enable  = in_re[g];
    assign rr_in[g].write_enable = in_we[g];
    assign rr_in[g].addr         = in_addr[g];
    assign rr_in[g].data         = in_data[g];
    assign rr_in[g].id           = in_id[g];
    assign fx_in[g].valid        = in_valid[g];
    assign fx_in[g].read_enable  = in_re[g];
    assign fx_in[g].write_enable = in_we[g];
    assign fx_in[g].addr         = in_addr[g];
    assign fx_in[g].data         = in_data[g];
    assign fx_in[g].id           = in_id[g];
    assign rr_rdy[g]             = rr_in[g].ready;
    assign fx_rdy[g]             = fx_in[g].ready;
  end

  assign p1_in[0].valid        = p1_valid;
  assign p1_in[0].read_enable  = p1_re;
  assign p1_in[0].write_enable = p1_we;
  assign p1_in[0].addr         = p1_addr;
  assign p1_in[0].data         = p1_data;
  assign p1_in[0].id           = p1_id;
  assign rr_out.ready          = out_ready;
  assign fx_out.ready          = out_ready;
  assign p1_out.ready          = out_ready;

  always_comb begin
    rr_gnt = '0;
    fx_gnt = '0;
    for (int i = 0; i < NP; i++) begin
      rr_gnt[i] = rr_rdy[i];
      fx_gnt[i] = fx_rdy[i];
    end
  end

  mem_merge #(.ARB_MODE(0), .PORTS(4), .META_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(16),
              .MASK_WIDTH(2), .PRE_ID_WIDTH(5), .OUT_ID_WIDTH(7)) u_rr (
    .clk(clk), .rst(rst), .mem_in(rr_in), .mem_in_meta(in_meta),
    .mem_out(rr_out), .mem_out_meta(rr_meta_o));

  mem_merge #(.ARB_MODE(1), .PORTS(4), .META_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(16),
              .MASK_WIDTH(2), .PRE_ID_WIDTH(5), .OUT_ID_WIDTH(7)) u_fx (
    .clk(clk), .rst(rst), .mem_in(fx_in), .mem_in_meta(in_meta),
    .mem_out(fx_out), .mem_out_meta(fx_meta_o));

  mem_merge #(.ARB_MODE(0), .PORTS(1), .META_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(16),
              .MASK_WIDTH(2), .PRE_ID_WIDTH(8), .OUT_ID_WIDTH(8)) u_p1 (
    .clk(clk), .rst(rst), .mem_in(p1_in), .mem_in_meta(p1_meta),
    .mem_out(p1_out), .mem_out_meta(p1_meta_o));

  // {re, we, addr, data, id (8b, zero-extended), meta}
  typedef logic [46:0] ent_t;
  ent_t rr_q[$];
  ent_t fx_q[$];
  ent_t p1_q[$];

  function automatic ent_t mk(input logic re, input logic [1:0] we, input logic [15:0] addr,
                              input logic [15:0] data, input logic [7:0] id, input logic [3:0] meta);
    return {re, we, addr, data, id, meta};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboards: a handshake seen at the negedge completes on the next posedge
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NP; k++) begin
        if (in_valid[k] && rr_rdy[k])
          rr_q.push_back(mk(in_re[k], in_we[k], in_addr[k], in_data[k], {1'b0, 2'(k), in_id[k]}, in_meta[k]));
        if (in_valid[k] && fx_rdy[k])
          fx_q.push_back(mk(in_re[k], in_we[k], in_addr[k], in_data[k], {1'b0, 2'(k), in_id[k]}, in_meta[k]));
      end
      if (p1_valid && p1_in[0].ready)
        p1_q.push_back(mk(p1_re, p1_we, p1_addr, p1_data, p1_id, p1_meta[0]));
      check("rr_onehot", 64'($countones(rr_gnt) <= 1), 64'd1);
      check("fx_onehot", 64'($countones(fx_gnt) <= 1), 64'd1);

      if (rr_out.valid && out_ready) begin
        if (rr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rr_sb unexpected output actual=%0h required=none", rr_out.addr);
        end else
          check("rr_sb", mk(rr_out.read_enable, rr_out.write_enable, rr_out.addr, rr_out.data,
                            {1'b0, rr_out.id}, rr_meta_o), rr_q.pop_front());
      end
      if (fx_out.valid && out_ready) begin
        if (fx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL fx_sb unexpected output actual=%0h required=none", fx_out.addr);
        end else
          check("fx_sb", mk(fx_out.read_enable, fx_out.write_enable, fx_out.addr, fx_out.data,
                            {1'b0, fx_out.id}, fx_meta_o), fx_q.pop_front());
      end
      if (p1_out.valid && out_ready) begin
        if (p1_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL p1_sb unexpected output actual=%0h required=none", p1_out.addr);
        end else
          check("p1_sb", mk(p1_out.read_enable, p1_out.write_enable, p1_out.addr, p1_out.data,
                            p1_out.id, p1_meta_o), p1_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < NP; k++) in_valid[k] = 1'b0;
    p1_valid = 1'b0;
  endtask

  task automatic rand_payload();
    for (int k = 0; k < NP; k++) begin
      in_re[k]   = 1'($urandom);
      in_we[k]   = 2'($urandom);
      in_addr[k] = 16'($urandom);
      in_data[k] = 16'($urandom);
      in_id[k]   = 5'($urandom);
      in_meta[k] = 4'($urandom);
    end
    p1_re      = 1'($urandom);
    p1_we      = 2'($urandom);
    p1_addr    = 16'($urandom);
    p1_data    = 16'($urandom);
    p1_id      = 8'($urandom);
    p1_meta[0] = 4'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rr_q.delete();
    fx_q.delete();
    p1_q.delete();
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 1'b1;
    repeat (6) tick();
    check("rr_drain_empty", 64'(rr_q.size()), 64'd0);
    check("fx_drain_empty", 64'(fx_q.size()), 64'd0);
    check("p1_drain_empty", 64'(p1_q.size()), 64'd0);
  endtask

  task automatic load_bp_item(input int n);
    in_valid[0] = 1'b1;
    in_re[0]    = 1'b1;
    in_we[0]    = 2'b01;
    in_addr[0]  = 16'hA000 + 16'(n);
    in_data[0]  = 16'h5000 + 16'(n);
    in_id[0]    = 5'(n);
    in_meta[0]  = 4'(n);
  endtask

  typedef struct packed {
    logic [3:0] mask;    // input valids, bit k = port k
    logic [3:0] rr_exp;  // expected round-robin grant
    logic [3:0] fx_exp;  // expected fixed-priority grant
  } vec_t;

  vec_t tbl [14];
  int   sent;

  initial begin
    tbl[0]  = {4'b1111, 4'b0001, 4'b0001};
    tbl[1]  = {4'b1111, 4'b0010, 4'b0001};
    tbl[2]  = {4'b1111, 4'b0100, 4'b0001};
    tbl[3]  = {4'b1111, 4'b1000, 4'b0001};
    tbl[4]  = {4'b1111, 4'b0001, 4'b0001};
    tbl[5]  = {4'b1111, 4'b0010, 4'b0001};
    tbl[6]  = {4'b1010, 4'b1000, 4'b0010};
    tbl[7]  = {4'b1010, 4'b0010, 4'b0010};
    tbl[8]  = {4'b1010, 4'b1000, 4'b0010};
    tbl[9]  = {4'b1000, 4'b1000, 4'b1000};
    tbl[10] = {4'b0000, 4'b0000, 4'b0000};
    tbl[11] = {4'b0100, 4'b0100, 4'b0100};
    tbl[12] = {4'b0001, 4'b0001, 4'b0001};
    tbl[13] = {4'b0101, 4'b0100, 4'b0001};

    out_ready = 1'b1;
    rand_payload();
    for (int k = 0; k < NP; k++) in_valid[k] = 1'b1;
    p1_valid = 1'b1;

    // Reset state with every input requesting
    #1 rst = 1'b1;
    #1;
    check("reset_rr_valid", 64'(rr_out.valid), 64'd0);
    check("reset_fx_valid", 64'(fx_out.valid), 64'd0);
    check("reset_p1_valid", 64'(p1_out.valid), 64'd0);
    check("reset_rr_ready", 64'(rr_gnt), 64'd0);
    check("reset_fx_ready", 64'(fx_gnt), 64'd0);
    check("reset_p1_ready", 64'(p1_in[0].ready), 64'd0);
    do_reset();

    // Arbitration table, output always ready
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rand_payload();
      for (int k = 0; k < NP; k++) in_valid[k] = tbl[i].mask[k];
      @(negedge clk);
      check($sformatf("tbl%0d_rr_grant", i), 64'(rr_gnt), 64'(tbl[i].rr_exp));
      check($sformatf("tbl%0d_fx_grant", i), 64'(fx_gnt), 64'(tbl[i].fx_exp));
      tick();
    end
    drain();

    // Single request latency and id tagging
    do_reset();
    out_ready = 1'b1;
    rand_payload();
    in_valid[2] = 1'b1;
    in_id[2]    = 5'h03;
    in_addr[2]  = 16'h0040;
    @(negedge clk);
    check("lat_grant", 64'(rr_gnt), 64'b0100);
    check("lat_valid_c0", 64'(rr_out.valid), 64'd0);
    tick();
    in_valid[2] = 1'b0;
    @(negedge clk);
    check("lat_valid_c1", 64'(rr_out.valid), 64'd1);
    check("lat_id", 64'(rr_out.id), 64'h43);
    check("lat_addr", 64'(rr_out.addr), 64'h40);
    tick();
    drain();

    // Backpressure: port 0 streams A..D into a stalled output
    do_reset();
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      load_bp_item(sent);
      @(negedge clk);
      check($sformatf("bp_ready_c%0d", c), 64'(rr_rdy[0]), 64'(c < 2));
      if (c >= 1) begin
        check("bp_head_valid", 64'(rr_out.valid), 64'd1);
        check("bp_head_addr", 64'(rr_out.addr), 64'hA000);
      end
      if (rr_rdy[0]) sent++;
      tick();
    end
    check("bp_accepted", 64'(sent), 64'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sent < 4; c++) begin
      load_bp_item(sent);
      @(negedge clk);
      if (rr_rdy[0]) sent++;
      tick();
    end
    check("bp_all_sent", 64'(sent), 64'd4);
    drain();

    // Reset with a full FIFO and the RR pointer moved off zero
    do_reset();
    out_ready = 1'b0;
    rand_payload();
    in_valid[1] = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    in_valid[1] = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", 64'(rr_out.valid), 64'd1);
    tick();
    rst = 1'b1;
    rr_q.delete();
    fx_q.delete();
    p1_q.delete();
    in_valid[0] = 1'b1;
    in_valid[2] = 1'b1;
    out_ready   = 1'b1;
    #1;
    check("rst_async_rr_valid", 64'(rr_out.valid), 64'd0);
    check("rst_async_fx_valid", 64'(fx_out.valid), 64'd0);
    check("rst_async_rr_ready", 64'(rr_gnt), 64'd0);
    check("rst_async_fx_ready", 64'(fx_gnt), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_first_rr_grant", 64'(rr_gnt), 64'b0001);
    check("rst_first_fx_grant", 64'(fx_gnt), 64'b0001);
    tick();
    drain();

    // Single port: id passes through untouched
    do_reset();
    out_ready = 1'b1;
    rand_payload();
    p1_valid = 1'b1;
    p1_id    = 8'hA5;
    @(negedge clk);
    check("p1_grant", 64'(p1_in[0].ready), 64'd1);
    tick();
    p1_valid = 1'b0;
    @(negedge clk);
    check("p1_valid", 64'(p1_out.valid), 64'd1);
    check("p1_id", 64'(p1_out.id), 64'hA5);
    tick();
    drain();

    // Random valid / random ready soak on all instances
    for (int c = 0; c < 10000; c++) begin
      rand_payload();
      for (int k = 0; k < NP; k++) in_valid[k] = 1'($urandom);
      p1_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_merge.md
MEM_MERGE -- requirements
Module: mem_merge

Interface
REQ-001 Parameter CLOCK_INFO, default 'b0, std_clock_info_t clock descriptor, passed through unused by the datapath.
REQ-002 Parameter ARB_MODE, default STREAM_SELECT_MODE_ROUND_ROBIN, arbitration policy.
- ROUND_ROBIN: rotating priority.
- Any other value: fixed priority, lowest index wins.
REQ-003 Parameter PORTS, default 2, number of request inputs, legal range 1..16.
REQ-004 Parameter META_WIDTH, default 1, width of sideband meta carried with each request.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 mem_in  mem_intf.in  array [PORTS]  request inputs.
- Fields: valid, ready, read_enable, write_enable[MASK_WIDTH], addr[ADDR_WIDTH], data[DATA_WIDTH], id[PRE_ID_WIDTH].
REQ-008 mem_in_meta  input  META_WIDTH x [PORTS]  meta per input, qualified by mem_in[k].valid.
REQ-009 mem_out  mem_intf.out  single  merged request output; same fields; id width OUT_ID_WIDTH.
REQ-010 mem_out_meta  output  META_WIDTH  meta of the request currently on mem_out.
REQ-011 SUB_ID_WIDTH SHALL be $clog2(PORTS) when PORTS>1, else 1.
REQ-012 Width checks, each a static assertion:
- OUT_ID_WIDTH == PRE_ID_WIDTH + SUB_ID_WIDTH when PORTS>1, else == PRE_ID_WIDTH.
- addr, data and write_enable widths identical on all ports.

Function
REQ-013 Output stage SHALL be a 2-entry FIFO (skid) holding {read_enable, write_enable, addr, data, id, meta}; mem_out reflects the head entry; mem_out.valid = (count != 0).
REQ-014 Grant gating: a grant SHALL be issued only when count < 2, or when count == 2 and mem_out.ready is high this cycle; at most one grant per cycle.
REQ-015 mem_in[k].ready SHALL equal grant[k].
- grant[k] depends only on input valids, arbiter state, count and mem_out.ready.
- grant[k] never depends on mem_in[k].ready.
REQ-016 The granted request SHALL be written to the FIFO tail on the grant edge; it appears on mem_out no earlier than 1 cycle after acceptance (latency 1 when FIFO empty).
REQ-017 Id re-attachment: written id SHALL be {k[SUB_ID_WIDTH-1:0], mem_in[k].id} when PORTS>1, and mem_in[k].id unchanged when PORTS==1.
REQ-018 Round-robin pointer update:
- After granting port k, the pointer becomes (k+1) mod PORTS.
- Priority searches upward from the pointer, wrapping.
- No grant: pointer unchanged.
REQ-019 Fixed mode: lowest valid index wins; pointer unused.
REQ-020 Pop occurs when mem_out.valid && mem_out.ready.
- Push and pop in the same cycle leave count unchanged.
- Order SHALL be preserved: FIFO, no reordering.
REQ-021 Head fields SHALL remain stable while mem_out.valid && !mem_out.ready.
REQ-022 Throughput: with mem_out.ready held high and any input valid, one request SHALL be accepted every cycle.
REQ-023 read_enable, write_enable, addr, data and meta SHALL pass unmodified; no filtering of requests with read_enable=0 and write_enable=0.

Reset
REQ-024 On rst assertion, asynchronously and without waiting for clk:
- count = 0, mem_out.valid = 0, all mem_in[k].ready = 0, RR pointer = 0.
REQ-025 FIFO payload storage need not be reset; mem_out payload fields are don't-care while valid = 0.
REQ-026 Reset mid-operation SHALL discard all buffered requests; the first post-reset grant follows pointer = 0 priority.

Verification
REQ-027 Single port: PORTS=4; port 2 sends id=5'h03, addr=0x40, with ready high.
- Accepted cycle 0; mem_out.valid in cycle 1 with id={2'b10,5'h03}, addr=0x40.
REQ-028 Round-robin: PORTS=4, all ports continuously valid, ready high.
- Grant order 0,1,2,3,0,1; exactly one accept per cycle.
REQ-029 Backpressure: ready low for 5 cycles while port 0 streams A,B,C,D.
- Exactly 2 accepted (A,B), then all mem_in.ready low.
- On ready high, output order A,B,C,D with no loss or duplication; head stable while stalled.
REQ-030 Fixed priority: ports 1 and 3 both valid for 3 cycles.
- Port 1 granted all 3 cycles; port 3 granted only after port 1 drops valid.
REQ-031 Reset mid-stream: assert rst with count=2.
- mem_out.valid falls to 0 immediately, before the next clock edge.
- After release, with ports 0 and 2 valid, port 0 is granted first.
REQ-032 PORTS=1: request with id=8'hA5 emerges with id=8'hA5; random-valid/random-ready soak of 10k cycles shows scoreboard match in order.
